// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match sequencer and its neighbours:
// frame/miss events and CPU control in, video strobes and status out.
interface pong_match_ctrl_if;
    logic       frame_start;
    logic       miss0;
    logic       miss1;
    logic       cfg_we;
    logic [7:0] cfg_data;
    logic       game_rst;
    logic       serv_ball;
    logic [3:0] score0;
    logic [3:0] score1;
    logic       server;
    logic       game_over;
    logic [2:0] state_o;
    logic       point_irq;

    modport master (
        output frame_start, miss0, miss1, cfg_we, cfg_data,
        input  game_rst, serv_ball, score0, score1, server, game_over, state_o, point_irq
    );

    modport slave (
        input  frame_start, miss0, miss1, cfg_we, cfg_data,
        output game_rst, serv_ball, score0, score1, server, game_over, state_o, point_irq
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: issues game reset / serve strobes, waits between
// points, scores misses, picks the next server and detects the end of match.
module pong_match_ctrl #(
    parameter int RST_PULSE   = 10,
    parameter int SERVE_PULSE = 10,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 11
) (
    input logic               sys_clk,
    input logic               rst_clk,
    pong_match_ctrl_if.slave  ctl
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RSTG  = 3'd1,
        S_WAIT  = 3'd2,
        S_SERVE = 3'd3,
        S_RALLY = 3'd4,
        S_POINT = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    localparam logic [3:0] RST_LEN    = 4'(RST_PULSE);
    localparam logic [3:0] SERVE_LEN  = 4'(SERVE_PULSE);
    localparam logic [7:0] DELAY_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t     r_state;
    logic [3:0] r_pulse_cnt;
    logic [7:0] r_frame_cnt;
    logic       r_game_rst;
    logic       r_serv_ball;
    logic [3:0] r_score0;
    logic [3:0] r_score1;
    logic       r_server;
    logic       r_game_over;
    logic       r_point_irq;
    logic       r_auto_serve;

    logic w_abort;
    logic w_start;
    logic w_serve_req;
    logic w_unused_cfg;

    assign w_abort      = ctl.cfg_we & ctl.cfg_data[1];
    assign w_start      = ctl.cfg_we & ctl.cfg_data[0];
    assign w_serve_req  = ctl.cfg_we & ctl.cfg_data[2];
    assign w_unused_cfg = ^ctl.cfg_data[6:3];

    always_ff @(posedge sys_clk or posedge rst_clk) begin
        if (rst_clk) begin
            r_state      <= S_IDLE;
            r_pulse_cnt  <= 4'd0;
            r_frame_cnt  <= 8'd0;
            r_game_rst   <= 1'b0;
            r_serv_ball  <= 1'b0;
            r_score0     <= 4'd0;
            r_score1     <= 4'd0;
            r_server     <= 1'b0;
            r_game_over  <= 1'b0;
            r_point_irq  <= 1'b0;
            r_auto_serve <= 1'b1;
        end else begin
            if (ctl.cfg_we) begin
                r_auto_serve <= ctl.cfg_data[7];
            end
            r_point_irq <= 1'b0;

            if (w_abort) begin
                // Scores and game_over survive an abort; strobes are cut.
                r_state     <= S_IDLE;
                r_game_rst  <= 1'b0;
                r_serv_ball <= 1'b0;
                r_pulse_cnt <= 4'd0;
            end else if (w_start) begin
                r_state     <= S_RSTG;
                r_game_rst  <= 1'b0;
                r_serv_ball <= 1'b0;
                r_pulse_cnt <= 4'd0;
                r_frame_cnt <= 8'd0;
                r_score0    <= 4'd0;
                r_score1    <= 4'd0;
                r_server    <= 1'b0;
                r_game_over <= 1'b0;
            end else begin
                case (r_state)
                    S_RSTG: begin
                        // game_rst rises one cycle after entry and lasts RST_PULSE cycles
                        if (r_pulse_cnt == RST_LEN) begin
                            r_game_rst  <= 1'b0;
                            r_frame_cnt <= 8'd0;
                            r_state     <= S_WAIT;
                        end else begin
                            r_game_rst  <= 1'b1;
                            r_pulse_cnt <= r_pulse_cnt + 4'd1;
                        end
                    end
                    S_WAIT: begin
                        if ((r_auto_serve && ctl.frame_start && r_frame_cnt == DELAY_LAST) ||
                            (!r_auto_serve && w_serve_req)) begin
                            r_state     <= S_SERVE;
                            r_serv_ball <= 1'b1;
                            r_pulse_cnt <= 4'd1;
                        end else if (r_auto_serve && ctl.frame_start) begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                    S_SERVE: begin
                        // serv_ball is already high on entry, so count starts at 1
                        if (r_pulse_cnt == SERVE_LEN) begin
                            r_serv_ball <= 1'b0;
                            r_state     <= S_RALLY;
                        end else begin
                            r_pulse_cnt <= r_pulse_cnt + 4'd1;
                        end
                    end
                    S_RALLY: begin
                        if (ctl.miss0 && ctl.miss1) begin
                            r_frame_cnt <= 8'd0;
                            r_state     <= S_WAIT;
                        end else if (ctl.miss0) begin
                            r_score1    <= r_score1 + 4'd1;
                            r_server    <= 1'b0;
                            r_point_irq <= 1'b1;
                            r_state     <= S_POINT;
                        end else if (ctl.miss1) begin
                            r_score0    <= r_score0 + 4'd1;
                            r_server    <= 1'b1;
                            r_point_irq <= 1'b1;
                            r_state     <= S_POINT;
                        end
                    end
                    S_POINT: begin
                        if (r_score0 == WIN || r_score1 == WIN) begin
                            r_game_over <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_frame_cnt <= 8'd0;
                            r_state     <= S_WAIT;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign ctl.game_rst  = r_game_rst;
    assign ctl.serv_ball = r_serv_ball;
    assign ctl.score0    = r_score0;
    assign ctl.score1    = r_score1;
    assign ctl.server    = r_server;
    assign ctl.game_over = r_game_over;
    assign ctl.state_o   = r_state;
    assign ctl.point_irq = r_point_irq;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: stimulus queues each expected output
// change with its cycle stamp; a monitor compares every observed change.
module tb_pong_match_ctrl;
    localparam int WIN = 3;

    typedef struct packed {
        logic [2:0] st;
        logic       grst;
        logic       sball;
        logic [3:0] s0;
        logic [3:0] s1;
        logic       srv;
        logic       gover;
        logic       pirq;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    logic sys_clk;
    logic rst_clk;
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    exp_t  q[$];
    snap_t e;

    pong_match_ctrl_if bus();

    pong_match_ctrl #(
        .RST_PULSE  (10),
        .SERVE_PULSE(10),
        .SERVE_DELAY(3),
        .WIN_SCORE  (WIN)
    ) dut (
        .sys_clk(sys_clk),
        .rst_clk(rst_clk),
        .ctl    (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic snap_t sample();
        snap_t s;
        s.st    = bus.state_o;
        s.grst  = bus.game_rst;
        s.sball = bus.serv_ball;
        s.s0    = bus.score0;
        s.s1    = bus.score1;
        s.srv   = bus.server;
        s.gover = bus.game_over;
        s.pirq  = bus.point_irq;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d grst=%b sball=%b s0=%0d s1=%0d srv=%b gover=%b irq=%b",
                         s.st, s.grst, s.sball, s.s0, s.s1, s.srv, s.gover, s.pirq);
    endfunction

    // Monitor: reset snapshot, then one comparison per output change
    initial begin
        snap_t cur;
        snap_t prev;
        exp_t  it;
        @(negedge sys_clk);
        cur = sample();
        checks++;
        if (cur !== snap_t'(0)) begin
            fails++;
            $display("FAIL reset_state: got %s, want all zero", fmt(cur));
        end else begin
            $display("cyc %0d reset ok: %s", cyc, fmt(cur));
        end
        prev = cur;
        forever begin
            @(negedge sys_clk);
            cur = sample();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: cyc %0d got %s, want no change", cyc, fmt(cur));
                end else begin
                    it = q.pop_front();
                    if (cur !== it.s || cyc != it.cyc) begin
                        fails++;
                        $display("FAIL output_change: got cyc %0d %s, want cyc %0d %s",
                                 cyc, fmt(cur), it.cyc, fmt(it.s));
                    end else begin
                        $display("cyc %0d ok: %s", cyc, fmt(cur));
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input int c);
        exp_t it;
        it.cyc = c;
        it.s   = e;
        q.push_back(it);
    endtask

    // Drive one cycle of inputs; c is the cycle whose edge samples them minus one
    task automatic drive(input logic fs, input logic m0, input logic m1,
                         input logic we, input logic [7:0] d, output int c);
        bus.frame_start = fs;
        bus.miss0       = m0;
        bus.miss1       = m1;
        bus.cfg_we      = we;
        bus.cfg_data    = d;
        c = cyc;
        step();
        bus.frame_start = 1'b0;
        bus.miss0       = 1'b0;
        bus.miss1       = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_data    = 8'h00;
    endtask

    task automatic cfg(input logic [7:0] d, output int c);
        drive(1'b0, 1'b0, 1'b0, 1'b1, d, c);
    endtask

    // Start a match; a frame_start lands on the WAIT-entry edge and must not count
    task automatic start_game(input logic [7:0] d);
        int c;
        int cf;
        cfg(d, c);
        e.st = 3'd1; e.s0 = 4'd0; e.s1 = 4'd0; e.srv = 1'b0; e.gover = 1'b0;
        push(c + 1);
        e.grst = 1'b1;
        push(c + 2);
        e.grst = 1'b0; e.st = 3'd2;
        push(c + 12);
        repeat (10) step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, cf);
    endtask

    // Three frames then the serve pulse; a miss during SERVE must be ignored
    task automatic serve_auto();
        int c;
        int cm;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, c);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, c);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, c);
        e.st = 3'd3; e.sball = 1'b1;
        push(c + 1);
        e.st = 3'd4; e.sball = 1'b0;
        push(c + 11);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, cm);
        repeat (9) step();
    endtask

    task automatic point(input logic m0, input logic m1);
        int c;
        drive(1'b0, m0, m1, 1'b0, 8'h00, c);
        if (m0 && m1) begin
            e.st = 3'd2;
            push(c + 1);
        end else begin
            e.st = 3'd5; e.pirq = 1'b1;
            if (m0) begin
                e.s1 = e.s1 + 4'd1; e.srv = 1'b0;
            end else begin
                e.s0 = e.s0 + 4'd1; e.srv = 1'b1;
            end
            push(c + 1);
            e.pirq = 1'b0;
            if (e.s0 == 4'(WIN) || e.s1 == 4'(WIN)) begin
                e.st = 3'd6; e.gover = 1'b1;
            end else begin
                e.st = 3'd2;
            end
            push(c + 2);
        end
        step();
    endtask

    initial begin
        int c;
        int c2;
        e = '0;
        rst_clk         = 1'b1;
        bus.frame_start = 1'b0;
        bus.miss0       = 1'b0;
        bus.miss1       = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_data    = 8'h00;
        repeat (3) step();
        rst_clk = 1'b0;
        step();

        // Auto-serve match to WIN, including a let
        start_game(8'h81);
        serve_auto(); point(1'b0, 1'b1);
        serve_auto(); point(1'b1, 1'b1);
        serve_auto(); point(1'b1, 1'b0);
        serve_auto(); point(1'b0, 1'b1);
        serve_auto(); point(1'b0, 1'b1);

        // OVER ignores misses and serve requests
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, c);
        step();
        cfg(8'h04, c);
        repeat (3) step();

        // Manual serve: frames alone never serve
        start_game(8'h01);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, c);
        end
        cfg(8'h04, c);
        e.st = 3'd3; e.sball = 1'b1;
        push(c + 1);
        e.st = 3'd4; e.sball = 1'b0;
        push(c + 11);
        repeat (10) step();
        point(1'b1, 1'b0);

        // Abort during the 5th serv_ball cycle, then abort beats start
        cfg(8'h04, c);
        e.st = 3'd3; e.sball = 1'b1;
        push(c + 1);
        repeat (4) step();
        cfg(8'h02, c2);
        e.st = 3'd0; e.sball = 1'b0;
        push(c2 + 1);
        step();
        cfg(8'h03, c);
        repeat (20) step();

        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations: got %0d still queued, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
